// File: rtl/bottling_pkg.sv
// Shared types for the pill-bottling controller:
// FSM states, fault codes, BCD digit width, input event bundle.
package bottling_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_SETTING   = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_SWITCHING = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4,
        ST_FATAL     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_HOPPER   = 2'd1,
        FLT_CONVEYOR = 2'd2,
        FLT_ESTOP    = 2'd3
    } fault_t;

    typedef struct packed {
        logic pulse;
        logic next;
        logic start;
        logic clr;
        logic pill;
    } edge_t;

endpackage

// File: rtl/bottling_ctrl_if.sv
// Panel, sensor and display bundle of the bottling controller.
// master = panel/sensor side, slave = controller.
interface bottling_ctrl_if #(
    parameter int PILL_DIGITS   = 3,
    parameter int BOTTLE_DIGITS = 2
);
    localparam int PW = bottling_pkg::BCD_W * PILL_DIGITS;
    localparam int BW = bottling_pkg::BCD_W * BOTTLE_DIGITS;
    localparam int NS = PILL_DIGITS + BOTTLE_DIGITS;

    logic          btn_pulse;
    logic          btn_next;
    logic          btn_start;
    logic          btn_clr;
    logic          emergncy_stop;
    logic          hopper_pill;
    logic          conveyor_ok;
    logic [2:0]    state;
    logic [PW-1:0] target_pills;
    logic [BW-1:0] target_bottles;
    logic [PW-1:0] now_pills;
    logic [BW-1:0] now_bottles;
    logic [NS-1:0] sel_mask;
    logic [1:0]    fault;
    logic          beep;

    modport master (
        output btn_pulse, btn_next, btn_start, btn_clr,
        output emergncy_stop, hopper_pill, conveyor_ok,
        input  state, target_pills, target_bottles,
        input  now_pills, now_bottles, sel_mask, fault, beep
    );

    modport slave (
        input  btn_pulse, btn_next, btn_start, btn_clr,
        input  emergncy_stop, hopper_pill, conveyor_ok,
        output state, target_pills, target_bottles,
        output now_pills, now_bottles, sel_mask, fault, beep
    );

endinterface

// File: rtl/bcd_counter.sv
// Multi-digit BCD register: clear, increment with carry,
// and carry-less per-digit increment for target entry.
module bcd_counter
    import bottling_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    input  logic [DIGITS-1:0]       dig_inc,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic [BCD_W*DIGITS-1:0] q_inc
);
    logic [BCD_W*DIGITS-1:0] q_dig;
    logic                    carry;

    always_comb begin
        q_inc = q;
        q_dig = q;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (q[i*BCD_W +: BCD_W] == 4'd9) begin
                    q_inc[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    q_inc[i*BCD_W +: BCD_W] = q[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (dig_inc[i]) begin
                q_dig[i*BCD_W +: BCD_W] = (q[i*BCD_W +: BCD_W] == 4'd9)
                    ? 4'd0 : q[i*BCD_W +: BCD_W] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q_inc;
        end else if (|dig_inc) begin
            q <= q_dig;
        end
    end

endmodule

// File: rtl/bottling_ctrl.sv
// Pill-bottling controller: target entry, BCD counting, hopper/conveyor
// supervision, e-stop. Beeper pattern built only with BOTTLING_BEEP_EN.
module bottling_ctrl
    import bottling_pkg::*;
#(
    parameter int PILL_DIGITS   = 3,
    parameter int BOTTLE_DIGITS = 2,
    parameter int TICK_DIV      = 1000,
    parameter int SWITCH_SEC    = 2,
    parameter int HOPPER_SEC    = 3
) (
    input logic       clk_1khz,
    input logic       switch_clr,
    bottling_ctrl_if.slave bus
);
    localparam int NS      = PILL_DIGITS + BOTTLE_DIGITS;
    localparam int PW      = BCD_W * PILL_DIGITS;
    localparam int BW      = BCD_W * BOTTLE_DIGITS;
    localparam int SW_CYC  = SWITCH_SEC * TICK_DIV;
    localparam int HP_CYC  = HOPPER_SEC * TICK_DIV;
    localparam int MAX_CYC = (SW_CYC > HP_CYC) ? SW_CYC : HP_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);

    edge_t         in_q, in_qq, ev;
    logic          estop_q, conv_q;
    state_t        st;
    fault_t        flt;
    logic [TW-1:0] timer;
    logic [NS-1:0] sel;

    logic [PW-1:0] tgt_p, cnt_p, cnt_p_inc, tp_unused;
    logic [BW-1:0] tgt_b, cnt_b, cnt_b_inc, tb_unused;
    logic          pill_hit, p_full, b_full, expire;
    logic          start_ok, resume, clr_go;
    logic          p_clr, p_inc, b_clr;
    logic [PILL_DIGITS-1:0]   tp_dig;
    logic [BOTTLE_DIGITS-1:0] tb_dig;

    // Inputs registered once; button/pill actions use a registered edge
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            in_q    <= '0;
            in_qq   <= '0;
            ev      <= '0;
            estop_q <= 1'b0;
            conv_q  <= 1'b0;
        end else begin
            in_q    <= '{pulse: bus.btn_pulse, next: bus.btn_next,
                         start: bus.btn_start, clr: bus.btn_clr,
                         pill: bus.hopper_pill};
            in_qq   <= in_q;
            ev      <= edge_t'(in_q & ~in_qq);
            estop_q <= bus.emergncy_stop;
            conv_q  <= bus.conveyor_ok;
        end
    end

    always_comb begin
        pill_hit = (st == ST_RUNNING) && ev.pill && !estop_q;
        p_full   = pill_hit && (cnt_p_inc == tgt_p);
        b_full   = p_full && (cnt_b_inc == tgt_b);
        expire   = ((st == ST_RUNNING) || (st == ST_SWITCHING))
                   && (timer == TW'(1)) && !estop_q && !pill_hit;
        start_ok = (st == ST_SETTING) && ev.start && !estop_q
                   && (|tgt_p) && (|tgt_b);
        resume   = (st == ST_ERROR) && ev.start && !estop_q;
        clr_go   = ((st == ST_ERROR) || (st == ST_DONE))
                   && ev.clr && !estop_q && !resume;
        p_clr    = start_ok || clr_go || p_full;
        p_inc    = pill_hit && !p_full;
        b_clr    = start_ok || clr_go;
        tp_dig   = '0;
        tb_dig   = '0;
        if ((st == ST_SETTING) && ev.pulse && !estop_q) begin
            tp_dig = sel[PILL_DIGITS-1:0];
            tb_dig = sel[NS-1:PILL_DIGITS];
        end
    end

    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            st    <= ST_SETTING;
            flt   <= FLT_NONE;
            timer <= '0;
            sel   <= NS'(1);
        end else begin
            if (timer != '0) timer <= timer - TW'(1);
            if ((st == ST_SETTING) && ev.next && !estop_q) begin
                sel <= {sel[NS-2:0], sel[NS-1]};
            end
            unique case (1'b1)
                estop_q: begin
                    st  <= ST_FATAL;
                    flt <= FLT_ESTOP;
                end
                pill_hit: begin
                    timer <= TW'(HP_CYC);
                    if (b_full) begin
                        st <= ST_DONE;
                    end else if (p_full) begin
                        st    <= ST_SWITCHING;
                        timer <= TW'(SW_CYC);
                    end
                end
                expire: begin
                    if (st == ST_RUNNING) begin
                        st  <= ST_ERROR;
                        flt <= FLT_HOPPER;
                    end else if (conv_q) begin
                        st    <= ST_RUNNING;
                        timer <= TW'(HP_CYC);
                    end else begin
                        st  <= ST_ERROR;
                        flt <= FLT_CONVEYOR;
                    end
                end
                start_ok, resume: begin
                    st    <= ST_RUNNING;
                    flt   <= FLT_NONE;
                    timer <= TW'(HP_CYC);
                end
                clr_go: begin
                    st  <= ST_SETTING;
                    flt <= FLT_NONE;
                end
                default: ;
            endcase
        end
    end

    bcd_counter #(.DIGITS(PILL_DIGITS)) u_tgt_p (
        .clk(clk_1khz), .rst(switch_clr), .clr(1'b0), .inc(1'b0),
        .dig_inc(tp_dig), .q(tgt_p), .q_inc(tp_unused)
    );

    bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_tgt_b (
        .clk(clk_1khz), .rst(switch_clr), .clr(1'b0), .inc(1'b0),
        .dig_inc(tb_dig), .q(tgt_b), .q_inc(tb_unused)
    );

    bcd_counter #(.DIGITS(PILL_DIGITS)) u_cnt_p (
        .clk(clk_1khz), .rst(switch_clr), .clr(p_clr), .inc(p_inc),
        .dig_inc('0), .q(cnt_p), .q_inc(cnt_p_inc)
    );

    bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_cnt_b (
        .clk(clk_1khz), .rst(switch_clr), .clr(b_clr), .inc(p_full),
        .dig_inc('0), .q(cnt_b), .q_inc(cnt_b_inc)
    );

    assign bus.state          = st;
    assign bus.fault          = flt;
    assign bus.target_pills   = tgt_p;
    assign bus.target_bottles = tgt_b;
    assign bus.now_pills      = cnt_p;
    assign bus.now_bottles    = cnt_b;
    assign bus.sel_mask       = (st == ST_SETTING) ? sel : '0;

`ifdef BOTTLING_BEEP_EN
    // Half-periods of the 2 Hz (ERROR) and 4 Hz (FATAL) patterns
    localparam int H2 = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
    localparam int H4 = (TICK_DIV / 8 > 0) ? TICK_DIV / 8 : 1;
    localparam int DW = $clog2(H2 + 1);

    logic [DW-1:0] div2, div4;
    logic          sq2, sq4, beep_q;

    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            div2   <= '0;
            div4   <= '0;
            sq2    <= 1'b0;
            sq4    <= 1'b0;
            beep_q <= 1'b0;
        end else begin
            if (div2 == DW'(H2 - 1)) begin
                div2 <= '0;
                sq2  <= ~sq2;
            end else begin
                div2 <= div2 + DW'(1);
            end
            if (div4 == DW'(H4 - 1)) begin
                div4 <= '0;
                sq4  <= ~sq4;
            end else begin
                div4 <= div4 + DW'(1);
            end
            beep_q <= (st == ST_DONE)
                      || ((st == ST_ERROR) && sq2)
                      || ((st == ST_FATAL) && sq4);
        end
    end

    assign bus.beep = beep_q;
`else
    assign bus.beep = 1'b0;
`endif

endmodule

// File: tb/tb_bottling_ctrl.sv
// Self-checking bench for bottling_ctrl: directed scenarios plus
// randomized entry/dispensing against an integer reference model.
module tb_bottling_ctrl;
    import bottling_pkg::*;

    localparam int PD = 3;
    localparam int BD = 2;
    localparam int NS = PD + BD;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] btn   = '0;
    logic       hop   = 1'b0;
    logic       estop = 1'b0;
    logic       conv  = 1'b1;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    bottling_ctrl_if #(.PILL_DIGITS(PD), .BOTTLE_DIGITS(BD)) bus ();

    assign bus.btn_pulse     = btn[0];
    assign bus.btn_next      = btn[1];
    assign bus.btn_start     = btn[2];
    assign bus.btn_clr       = btn[3];
    assign bus.hopper_pill   = hop;
    assign bus.emergncy_stop = estop;
    assign bus.conveyor_ok   = conv;

    bottling_ctrl #(.PILL_DIGITS(PD), .BOTTLE_DIGITS(BD)) dut (
        .clk_1khz  (clk),
        .switch_clr(rst),
        .bus       (bus)
    );

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = '0; hop = 1'b0; estop = 1'b0; conv = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // 0 pulse, 1 next, 2 start, 3 clr
    task automatic press(input int b);
        btn[b] = 1'b1;
        tick(1);
        btn[b] = 1'b0;
        tick(3);
    endtask

    task automatic pill();
        hop = 1'b1;
        tick(1);
        hop = 1'b0;
        tick(2);
    endtask

    task automatic set_targets(input int p, input int b);
        int x;
        do_reset();
        x = p;
        for (int i = 0; i < PD; i++) begin
            repeat (x % 10) press(0);
            press(1);
            x = x / 10;
        end
        x = b;
        for (int i = 0; i < BD; i++) begin
            repeat (x % 10) press(0);
            press(1);
            x = x / 10;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.state);
        else passed++;
        total++;
        if ({bus.target_pills, bus.target_bottles, bus.now_pills, bus.now_bottles} !== '0)
            $display("FAIL reset_bcd: got %h %h %h %h want 0", bus.target_pills,
                     bus.target_bottles, bus.now_pills, bus.now_bottles);
        else passed++;
        total++;
        if (bus.sel_mask !== 5'b00001) $display("FAIL reset_sel: got %b want 00001", bus.sel_mask);
        else passed++;
        total++;
        if ({bus.fault, bus.beep} !== 3'b000)
            $display("FAIL reset_fault_beep: got %0d %0d want 0 0", bus.fault, bus.beep);
        else passed++;
    endtask

    task automatic test_setting();
        int d[NS];
        int msel;
        int op;
        logic [4*PD-1:0] ep;
        logic [4*BD-1:0] eb;
        logic [NS-1:0]   es;
        do_reset();
        repeat (11) press(0);
        total++;
        if (bus.target_pills !== 12'h001) $display("FAIL pulse_wrap: got %h want 001", bus.target_pills);
        else passed++;
        btn[1] = 1'b1;
        tick(10);
        btn[1] = 1'b0;
        tick(3);
        total++;
        if (bus.sel_mask !== 5'b00010) $display("FAIL held_next: got %b want 00010", bus.sel_mask);
        else passed++;
        repeat (4) press(1);
        total++;
        if (bus.sel_mask !== 5'b00001) $display("FAIL next_wrap: got %b want 00001", bus.sel_mask);
        else passed++;
        press(2);
        total++;
        if (bus.state !== 3'd0) $display("FAIL zero_target_start: got %0d want 0", bus.state);
        else passed++;
        foreach (d[i]) d[i] = 0;
        d[0] = 1;
        msel = 0;
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 1);
            press(op);
            if (op == 0) d[msel] = (d[msel] + 1) % 10;
            else msel = (msel + 1) % NS;
            ep = '0;
            eb = '0;
            for (int i = 0; i < PD; i++) ep[i*4 +: 4] = 4'(d[i]);
            for (int i = 0; i < BD; i++) eb[i*4 +: 4] = 4'(d[PD+i]);
            es = NS'(1 << msel);
            total++;
            if ({bus.target_pills, bus.target_bottles} !== {ep, eb})
                $display("FAIL rand_entry: got %h/%h want %h/%h", bus.target_pills,
                         bus.target_bottles, ep, eb);
            else passed++;
            total++;
            if (bus.sel_mask !== es) $display("FAIL rand_sel: got %b want %b", bus.sel_mask, es);
            else passed++;
        end
    endtask

    task automatic test_full_run();
        set_targets(3, 2);
        press(2);
        total++;
        if (bus.state !== 3'd1) $display("FAIL run_start: got %0d want 1", bus.state);
        else passed++;
        pill(); tick(497);
        pill(); tick(497);
        pill();
        total++;
        if ({bus.state, bus.now_bottles, bus.now_pills} !== {3'd2, 8'h01, 12'h000})
            $display("FAIL run_switch: got %0d %h %h want 2 01 000", bus.state,
                     bus.now_bottles, bus.now_pills);
        else passed++;
        pill();
        total++;
        if (bus.now_pills !== 12'h000) $display("FAIL switch_ignore: got %h want 000", bus.now_pills);
        else passed++;
        tick(1996);
        total++;
        if (bus.state !== 3'd2) $display("FAIL switch_dwell: got %0d want 2", bus.state);
        else passed++;
        tick(1);
        total++;
        if (bus.state !== 3'd1) $display("FAIL switch_end: got %0d want 1", bus.state);
        else passed++;
        pill(); tick(497);
        pill(); tick(497);
        pill();
        total++;
        if ({bus.state, bus.now_bottles, bus.now_pills} !== {3'd3, 8'h02, 12'h000})
            $display("FAIL run_done: got %0d %h %h want 3 02 000", bus.state,
                     bus.now_bottles, bus.now_pills);
        else passed++;
        tick(2);
        total++;
`ifdef BOTTLING_BEEP_EN
        if (bus.beep !== 1'b1) $display("FAIL done_beep: got %0d want 1", bus.beep);
`else
        if (bus.beep !== 1'b0) $display("FAIL done_beep: got %0d want 0", bus.beep);
`endif
        else passed++;
    endtask

    task automatic test_hopper_timeout();
        int cyc;
        int last;
        int nchg;
        logic prev;
        set_targets(5, 1);
        press(2);
        hop = 1'b1;
        tick(1);
        hop = 1'b0;
        tick(1);
        total++;
        if (bus.now_pills !== 12'h000) $display("FAIL pill_latency_early: got %h want 000", bus.now_pills);
        else passed++;
        tick(1);
        total++;
        if (bus.now_pills !== 12'h001) $display("FAIL pill_latency: got %h want 001", bus.now_pills);
        else passed++;
        pill();
        cyc = 0;
        while (bus.state === 3'd1 && cyc < 4000) begin
            tick(1);
            cyc++;
        end
        total++;
        if (cyc != 3000 || bus.state !== 3'd4)
            $display("FAIL hopper_timeout: got %0d cycles state %0d want 3000 state 4", cyc, bus.state);
        else passed++;
        total++;
        if (bus.fault !== 2'd1) $display("FAIL hopper_fault: got %0d want 1", bus.fault);
        else passed++;
        tick(5);
        prev = bus.beep;
        last = -1;
        nchg = 0;
        for (int i = 0; i < 1100; i++) begin
            tick(1);
            if (bus.beep !== prev) begin
                if (last >= 0) begin
                    total++;
                    if (i - last != 250) $display("FAIL beep_period: got %0d want 250", i - last);
                    else passed++;
                end
                last = i;
                prev = bus.beep;
                nchg++;
            end
        end
        total++;
`ifdef BOTTLING_BEEP_EN
        if (nchg < 4) $display("FAIL error_beep: got %0d toggles want >=4", nchg);
`else
        if (nchg != 0 || bus.beep !== 1'b0) $display("FAIL error_beep: got %0d toggles want 0", nchg);
`endif
        else passed++;
        press(2);
        total++;
        if ({bus.state, bus.fault, bus.now_pills} !== {3'd1, 2'd0, 12'h002})
            $display("FAIL resume: got %0d %0d %h want 1 0 002", bus.state, bus.fault, bus.now_pills);
        else passed++;
    endtask

    task automatic test_conveyor_fault();
        int cyc;
        set_targets(2, 3);
        press(2);
        pill();
        pill();
        total++;
        if (bus.state !== 3'd2) $display("FAIL conv_switch: got %0d want 2", bus.state);
        else passed++;
        conv = 1'b0;
        cyc = 0;
        while (bus.state === 3'd2 && cyc < 2100) begin
            tick(1);
            cyc++;
        end
        total++;
        if ({bus.state, bus.fault} !== {3'd4, 2'd2})
            $display("FAIL conv_fault: got %0d %0d want 4 2", bus.state, bus.fault);
        else passed++;
        press(3);
        conv = 1'b1;
        total++;
        if ({bus.state, bus.fault, bus.target_pills, bus.target_bottles} !== {3'd0, 2'd0, 12'h002, 8'h03})
            $display("FAIL conv_clr: got %0d %0d %h %h want 0 0 002 03", bus.state,
                     bus.fault, bus.target_pills, bus.target_bottles);
        else passed++;
        total++;
        if ({bus.now_pills, bus.now_bottles} !== '0)
            $display("FAIL conv_clr_counts: got %h %h want 0", bus.now_pills, bus.now_bottles);
        else passed++;
    endtask

    task automatic test_estop();
        set_targets(4, 2);
        press(2);
        pill();
        estop = 1'b1;
        hop = 1'b1;
        tick(1);
        hop = 1'b0;
        tick(3);
        total++;
        if ({bus.state, bus.fault, bus.now_pills} !== {3'd5, 2'd3, 12'h001})
            $display("FAIL estop: got %0d %0d %h want 5 3 001", bus.state, bus.fault, bus.now_pills);
        else passed++;
        estop = 1'b0;
        press(2);
        press(3);
        total++;
        if ({bus.state, bus.fault, bus.now_pills} !== {3'd5, 2'd3, 12'h001})
            $display("FAIL fatal_sticky: got %0d %0d %h want 5 3 001", bus.state, bus.fault, bus.now_pills);
        else passed++;
        do_reset();
        total++;
        if ({bus.state, bus.fault, bus.sel_mask, bus.beep} !== {3'd0, 2'd0, 5'b00001, 1'b0})
            $display("FAIL fatal_reset: got %0d %0d %b %0d want 0 0 00001 0", bus.state,
                     bus.fault, bus.sel_mask, bus.beep);
        else passed++;
        total++;
        if ({bus.target_pills, bus.target_bottles, bus.now_pills, bus.now_bottles} !== '0)
            $display("FAIL fatal_reset_bcd: got %h %h %h %h want 0", bus.target_pills,
                     bus.target_bottles, bus.now_pills, bus.now_bottles);
        else passed++;
    endtask

    task automatic test_random_run();
        int tp, tbt, mp, mb, cyc, es;
        logic [11:0] ep;
        logic [7:0]  eb;
        for (int k = 0; k < 3; k++) begin
            tp  = (k == 0) ? 99 : $urandom_range(1, 30);
            tbt = (k == 0) ? 1 : $urandom_range(1, 3);
            set_targets(tp, tbt);
            press(2);
            mp = 0;
            mb = 0;
            while (mb < tbt) begin
                pill();
                mp++;
                es = 1;
                if (mp == tp) begin
                    mp = 0;
                    mb++;
                    es = (mb == tbt) ? 3 : 2;
                end
                ep = 12'(to_bcd(mp));
                eb = 8'(to_bcd(mb));
                total++;
                if ({bus.now_pills, bus.now_bottles} !== {ep, eb})
                    $display("FAIL rand_count: got %h %h want %h %h", bus.now_pills,
                             bus.now_bottles, ep, eb);
                else passed++;
                total++;
                if (bus.state !== 3'(es)) $display("FAIL rand_state: got %0d want %0d", bus.state, es);
                else passed++;
                if (es == 2) begin
                    cyc = 0;
                    while (bus.state === 3'd2 && cyc < 2100) begin
                        tick(1);
                        cyc++;
                    end
                    total++;
                    if (bus.state !== 3'd1) $display("FAIL rand_resume: got %0d want 1", bus.state);
                    else passed++;
                end
                tick($urandom_range(1, 30));
            end
        end
    endtask

    initial begin
        test_reset();
        test_setting();
        test_full_run();
        test_hopper_timeout();
        test_conveyor_fault();
        test_estop();
        test_random_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
